clkgate_ctrl: RTL and testbench

Idle-detect controller that drives the `gate` enable input of the `clkgate` cell: it watches activity of the gated domain, drops `gate` after a programmable number of consecutive idle cycles, and restores it on wake-up with a fixed settle window before reporting the domain running. It runs on the free-running (ungated) `clk` that also feeds `clkgate`. `gate` is a registered posedge output. The latch in `clkgate` is transparent during clock-low, so `gclk` stays glitch-free.

---
 rtl/clkgate_pkg.sv | 15 +
 rtl/clkgate_ctrl.sv | 103 ++++++++++
 tb/tb_clkgate_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/clkgate_pkg.sv
// Shared definitions for the clock-gate idle controller: state encoding
// and the default sizing parameters used by clkgate_ctrl.
package clkgate_pkg;

  localparam int IDLE_W_DEF   = 8;
  localparam int WAKE_CYC_DEF = 2;

  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_COUNT = 2'd1,
    CG_GATED = 2'd2,
    CG_WAKE  = 2'd3
  } cg_state_e;

endpackage

// File: rtl/clkgate_ctrl.sv
// Idle-detect controller for a latch-based clock gate. Counts consecutive
// idle cycles of the gated domain, drops the gate enable once the
// programmed threshold is reached, and on any wake source re-enables the
// clock and waits a fixed settle window before reporting the domain running.
// Runs on the free-running clock; every output is a flop, so no input can
// reach an output combinationally.
module clkgate_ctrl
  import clkgate_pkg::*;
#(
  parameter int IDLE_W   = IDLE_W_DEF,
  parameter int WAKE_CYC = WAKE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sleep_en,
  input  logic              busy,
  input  logic              wake_req,
  input  logic [IDLE_W-1:0] idle_thresh,
  output logic              gate,
  output logic              gated,
  output logic              wake_ack
);

  localparam int WCNT_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAKE_CYC - 1);

  cg_state_e         state;
  logic [IDLE_W-1:0] cnt;
  logic [WCNT_W-1:0] wcnt;
  logic              idle;

  // The domain may only be gated when software allows it, it reports no
  // work, and nobody is asking it to wake.
  always_comb begin
    idle = sleep_en & ~busy & ~wake_req;
  end

  // Gate FSM: counts idle cycles, gates the clock, and sequences wake-up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CG_RUN;
      cnt      <= '0;
      wcnt     <= '0;
      gate     <= 1'b1;
      gated    <= 1'b0;
      wake_ack <= 1'b0;
    end else begin
      wake_ack <= 1'b0;
      case (state)
        CG_RUN: begin
          gate  <= 1'b1;
          gated <= 1'b0;
          if (idle) begin
            state <= CG_COUNT;
            cnt   <= '0;
          end
        end

        CG_COUNT: begin
          if (!idle) begin
            state <= CG_RUN;
            cnt   <= '0;
          end else if (cnt == idle_thresh) begin
            state <= CG_GATED;
            cnt   <= '0;
            gate  <= 1'b0;
            gated <= 1'b1;
          end else begin
            cnt <= cnt + IDLE_W'(1);
          end
        end

        CG_GATED: begin
          if (!idle) begin
            state <= CG_WAKE;
            wcnt  <= '0;
            gate  <= 1'b1;
            gated <= 1'b0;
          end
        end

        CG_WAKE: begin
          if (wcnt == WCNT_LAST) begin
            state    <= CG_RUN;
            wcnt     <= '0;
            wake_ack <= 1'b1;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end

        default: begin
          state <= CG_RUN;
          cnt   <= '0;
          wcnt  <= '0;
          gate  <= 1'b1;
          gated <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Self-checking bench for clkgate_ctrl. Stimulus is driven on the falling
// edge, a behavioural model predicts the outputs after the next rising
// edge, and a monitor compares them against the DUT. A behavioural
// latch-and-AND clock gate is attached to the gate output so gated clock
// pulses can be counted and measured.
module tb_clkgate_ctrl;

  localparam int IDLE_W   = 8;
  localparam int WAKE_CYC = 2;
  localparam int HALF     = 5;

  logic              clk;
  logic              rst_n;
  logic              sleep_en;
  logic              busy;
  logic              wake_req;
  logic [IDLE_W-1:0] idle_thresh;
  logic              gate;
  logic              gated;
  logic              wake_ack;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_q[$];

  // reference model state: consecutive idle samples while running,
  // whether the clock is off, and remaining settle cycles
  int m_streak  = 0;
  bit m_gated   = 0;
  int m_wake    = 0;
  bit m_ack     = 0;

  bit  count_on   = 0;
  int  gclk_edges = 0;
  int  exp_edges  = 0;
  time rise_t     = 0;
  time min_high   = 1000;
  bit  driver_done = 0;

  logic en_l;
  logic gclk;

  clkgate_ctrl #(.IDLE_W(IDLE_W), .WAKE_CYC(WAKE_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sleep_en   (sleep_en),
    .busy       (busy),
    .wake_req   (wake_req),
    .idle_thresh(idle_thresh),
    .gate       (gate),
    .gated      (gated),
    .wake_ack   (wake_ack)
  );

  initial begin
    clk = 1'b0;
    forever #HALF clk = ~clk;
  end

  // behavioural clock-gate cell: latch transparent while clk is low
  always @(clk or gate) begin
    if (!clk) en_l = gate;
  end
  assign gclk = clk & en_l;

  always @(posedge gclk) begin
    if (count_on) begin
      gclk_edges++;
      rise_t = $time;
    end
  end

  always @(negedge gclk) begin
    if (count_on && rise_t != 0 && ($time - rise_t) < min_high) min_high = $time - rise_t;
  end

  // predicts the DUT's outputs after the coming rising edge
  task automatic modelStep(input bit r, input bit s, input bit b, input bit w,
                           input logic [IDLE_W-1:0] t);
    bit idle;
    idle = s & ~b & ~w;
    m_ack = 0;
    if (!r) begin
      m_streak = 0;
      m_gated  = 0;
      m_wake   = 0;
    end else if (m_wake > 0) begin
      m_wake--;
      if (m_wake == 0) m_ack = 1;
    end else if (m_gated) begin
      if (!idle) begin
        m_gated = 0;
        m_wake  = WAKE_CYC;
      end
    end else if (idle) begin
      m_streak++;
      if (m_streak == int'(t) + 2) begin
        m_gated  = 1;
        m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit b, input bit w,
                               input logic [IDLE_W-1:0] t);
    @(negedge clk);
    rst_n       = r;
    sleep_en    = s;
    busy        = b;
    wake_req    = w;
    idle_thresh = t;
    count_on    = 1;
    if (!m_gated) exp_edges++;
    modelStep(r, s, b, w, t);
    exp_q.push_back({~m_gated, m_gated, m_ack});
  endtask

  task automatic runFor(input int n, input bit s, input bit b, input bit w,
                        input logic [IDLE_W-1:0] t);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, s, b, w, t);
  endtask

  task automatic checkOutput(input logic [2:0] exp);
    checks++;
    if ({gate, gated, wake_ack} !== exp) begin
      errors++;
      $display("[TB] FAIL outputs t=%0t: got gate/gated/ack=%b%b%b expected %b",
               $time, gate, gated, wake_ack, exp);
    end
  endtask

  // monitor: one prediction per rising edge, compared just after it
  initial begin
    logic [2:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // driver: directed scenarios followed by randomized traffic
  initial begin
    logic [IDLE_W-1:0] t;
    bit s, b, w, r;
    rst_n = 1'b0; sleep_en = 1'b0; busy = 1'b1; wake_req = 1'b0; idle_thresh = '0;

    applyStimulus(0, 0, 1, 0, 8'd3);
    applyStimulus(0, 0, 1, 0, 8'd3);

    // threshold 3: gate drops after the fifth idle edge
    runFor(4, 1, 1, 0, 8'd3);
    runFor(8, 1, 0, 0, 8'd3);
    // wake request: gate back, ack two edges later, inputs ignored meanwhile
    applyStimulus(1, 1, 0, 1, 8'd3);
    runFor(2, 1, 0, 0, 8'd3);
    runFor(3, 1, 1, 0, 8'd3);

    // reset while gated
    runFor(6, 1, 0, 0, 8'd0);
    applyStimulus(0, 1, 0, 0, 8'd0);
    runFor(2, 1, 1, 0, 8'd0);

    // threshold 0 then interrupted count at 5 and restart
    runFor(3, 1, 0, 0, 8'd0);
    runFor(4, 1, 1, 0, 8'd5);
    runFor(4, 1, 0, 0, 8'd5);
    applyStimulus(1, 1, 1, 0, 8'd5);
    runFor(9, 1, 0, 0, 8'd5);

    // wake request on the edge the threshold is reached keeps clock on
    runFor(4, 1, 1, 0, 8'd2);
    runFor(3, 1, 0, 0, 8'd2);
    applyStimulus(1, 1, 0, 1, 8'd2);
    runFor(2, 1, 1, 0, 8'd2);

    // sleep_en dropping while gated wakes exactly like wake_req
    runFor(5, 1, 0, 0, 8'd1);
    runFor(4, 0, 0, 0, 8'd1);

    // randomized traffic; threshold only changes outside a count
    t = 8'd2;
    for (int i = 0; i < 2000; i++) begin
      if (m_streak == 0 && $urandom_range(0, 7) == 0) t = IDLE_W'($urandom_range(0, 6));
      r = ($urandom_range(0, 99) != 0);
      s = ($urandom_range(0, 29) != 0);
      b = ($urandom_range(0, 9) == 0);
      w = ($urandom_range(0, 29) == 0);
      applyStimulus(r, s, b, w, t);
    end

    @(posedge clk);
    #2;
    count_on = 0;
    driver_done = 1;
  end

  initial begin
    wait (driver_done);
    #(4 * HALF);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending: %0d predictions never compared, expected 0", exp_q.size());
    end
    checks++;
    if (gclk_edges != exp_edges) begin
      errors++;
      $display("[TB] FAIL gclk_edges: got %0d expected %0d", gclk_edges, exp_edges);
    end
    checks++;
    if (min_high < HALF) begin
      errors++;
      $display("[TB] FAIL gclk_width: shortest high %0t expected at least %0d", min_high, HALF);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
